sdram_client_arbiter: RTL

- Upstream front end of the SDRAM controller. Arbitrates between two 32-bit clients (port 0 = instruction fetch, port 1 = data) using round-robin.
- Converts each client's valid/ready request into the controller's level-held request/finish handshake. Returns a one-cycle response pulse with read data.
- Only one controller request is outstanding at a time. Reads and writes are never issued together.

---
 rtl/sdram_client_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sdram_client_arbiter.sv
// sdram_client_arbiter: round-robin front end for the SDRAM controller.
// Ports: clk/reset, init_fin, c0_*/c1_* client req+resp, resp_rdata,
//   rd_*/wr_* controller req/fin handshake, busy, timeout_err (sticky).
module sdram_client_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd4096,
  parameter int          ADDR_W  = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_fin,
  input  logic        c0_valid,
  input  logic        c0_we,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  output logic        c0_ready,
  output logic        c0_resp_valid,
  input  logic        c1_valid,
  input  logic        c1_we,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  output logic        c1_ready,
  output logic        c1_resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] rd_addr,
  output logic        rd_req,
  input  logic        rd_fin,
  input  logic [31:0] rd_data,
  output logic [31:0] wr_addr,
  output logic        wr_req,
  input  logic        wr_fin,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        c0_resp_q, c0_resp_d;
  logic        c1_resp_q, c1_resp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        win;
  logic        grant;
  logic        fin;
  logic [31:0] sel_addr;
  logic [31:0] map_addr;

  // Byte address bits outside the mapped window are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c0_addr[31:ADDR_W], c0_addr[1:0],
                              c1_addr[31:ADDR_W], c1_addr[1:0]};

  always_comb begin
    // On a tie, the client that did not win last time goes next.
    if (c0_valid && c1_valid) win = ~last_grant_q;
    else                      win = c1_valid;
    grant = (state_q == IDLE) && init_fin
            && (c0_valid || c1_valid);
    sel_addr = win ? c1_addr : c0_addr;
    // Halfword address of a word: bit 0 always 0.
    map_addr = '0;
    map_addr[ADDR_W-2:1] = sel_addr[ADDR_W-1:2];
    fin = we_q ? wr_fin : rd_fin;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    rdata_d      = rdata_q;
    c0_resp_d    = 1'b0;
    c1_resp_d    = 1'b0;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = ISSUE;
          last_grant_d = win;
          owner_d      = win;
          we_d         = win ? c1_we : c0_we;
          addr_d       = map_addr;
          wdata_d      = win ? c1_wdata : c0_wdata;
          rd_req_d     = ~(win ? c1_we : c0_we);
          wr_req_d     = win ? c1_we : c0_we;
          cnt_d        = '0;
        end
      end
      ISSUE: begin
        if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        if (cnt_d >= TIMEOUT) tmo_d = 1'b1;
        if (fin) begin
          rd_req_d  = 1'b0;
          wr_req_d  = 1'b0;
          if (!we_q) rdata_d = rd_data;
          c0_resp_d = ~owner_q;
          c1_resp_d = owner_q;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        // Controller holds fin while it saw req high.
        if (!fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      rdata_q      <= '0;
      c0_resp_q    <= 1'b0;
      c1_resp_q    <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      rdata_q      <= rdata_d;
      c0_resp_q    <= c0_resp_d;
      c1_resp_q    <= c1_resp_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign c0_ready      = grant & ~win;
  assign c1_ready      = grant & win;
  assign c0_resp_valid = c0_resp_q;
  assign c1_resp_valid = c1_resp_q;
  assign resp_rdata    = rdata_q;
  assign rd_addr       = addr_q;
  assign wr_addr       = addr_q;
  assign wr_data       = wdata_q;
  assign rd_req        = rd_req_q;
  assign wr_req        = wr_req_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = tmo_q;

endmodule
